// File: rtl/seq_divider_32.sv
// 32-bit sequential restoring divider, signed or unsigned, one quotient bit per cycle.
// Operands are reduced to magnitudes on accept and the sign is restored when the result is loaded.
module seq_divider_32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_next;
  logic [31:0] dvd_q, dvs_q, rem_q;
  logic [4:0]  count;
  logic        q_neg, r_neg;

  logic        dividend_neg, divisor_neg;
  logic [31:0] dividend_mag, divisor_mag;
  logic [32:0] shifted, diff;
  logic        q_bit;
  logic [31:0] rem_step, quo_step;
  logic        last_step;

  always_comb begin
    dividend_neg = is_signed & dividend[31];
    divisor_neg  = is_signed & divisor[31];
    dividend_mag = dividend_neg ? 32'd0 - dividend : dividend;
    divisor_mag  = divisor_neg  ? 32'd0 - divisor  : divisor;
  end

  // One restoring step; the dividend register doubles as the quotient shift register.
  always_comb begin
    shifted   = {rem_q, dvd_q[31]};
    diff      = shifted - {1'b0, dvs_q};
    q_bit     = ~diff[32];
    rem_step  = q_bit ? diff[31:0] : shifted[31:0];
    quo_step  = {dvd_q[30:0], q_bit};
    last_step = (count == 5'd31);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (divisor == '0) ? DONE : RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      count       <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              dvd_q       <= dividend_mag;
              dvs_q       <= divisor_mag;
              rem_q       <= '0;
              count       <= '0;
              q_neg       <= dividend_neg ^ divisor_neg;
              r_neg       <= dividend_neg;
              div_by_zero <= 1'b0;
            end
          end
        end
        RUN: begin
          dvd_q <= quo_step;
          rem_q <= rem_step;
          count <= count + 5'd1;
          if (last_step) begin
            quotient  <= q_neg ? 32'd0 - quo_step : quo_step;
            remainder <= r_neg ? 32'd0 - rem_step : rem_step;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule
